// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Purpose:
//   Sequences a combinational, word-indexed instruction source. Owns the
//   fetch PC, drives the word address every cycle and buffers fetched words
//   together with their byte PCs in a small FIFO. Decode drains the FIFO head
//   over a valid/ready handshake. Redirects (branch/jump/trap) flush the
//   buffer and restart fetch. A misaligned redirect target or a fetch beyond
//   the end of the instruction source raises a sticky fault.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   synchronous active-low reset
//   imem_addr      out  32  word index {2'b00, fetch_pc[31:2]}
//   imem_instr     in   32  instruction word at imem_addr (same cycle)
//   redirect_valid in   1   one-cycle request to restart fetch
//   redirect_pc    in   32  byte address of the new fetch stream
//   out_valid      out  1   FIFO head valid
//   out_ready      in   1   decode accepts head
//   out_instr      out  32  head instruction
//   out_pc         out  32  head byte PC
//   fault          out  1   sticky fetch fault
//   fault_pc       out  32  byte PC that caused the fault
//   stall_cnt      out  32  saturating count of full-FIFO stall cycles
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_DEPTH  = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0]    MEM_DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetchPc_q, fetchPc_d;
  logic              fault_q, fault_d;
  logic [31:0]       faultPc_q, faultPc_d;
  logic [31:0]       stallCnt_q, stallCnt_d;

  logic [31:0]       pcMem_q    [FIFO_DEPTH];
  logic [31:0]       instrMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              pop;
  logic              push;
  logic              flush;
  logic              fifoFull;
  logic              inRange;
  logic              redirectTaken;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    ptrInc = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign imem_addr = {2'b00, fetchPc_q[31:2]};

  assign out_valid = (count_q != '0);
  assign out_instr = instrMem_q[rdPtr_q];
  assign out_pc    = pcMem_q[rdPtr_q];
  assign fault     = fault_q;
  assign fault_pc  = faultPc_q;
  assign stall_cnt = stallCnt_q;

  assign pop           = out_valid && out_ready;
  assign fifoFull      = (count_q == FULL_CNT);
  assign inRange       = ({2'b00, fetchPc_q[31:2]} < MEM_DEPTH_W);
  // Redirects are ignored while booting.
  assign redirectTaken = redirect_valid && (state_q != BOOT);

  // Next-state logic: normal sequencing first, then a taken redirect
  // overrides everything except the pop, which decode has already consumed.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    fault_d   = fault_q;
    faultPc_d = faultPc_q;
    push      = 1'b0;
    flush     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!inRange) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          faultPc_d = fetchPc_q;
        end else if (!fifoFull || pop) begin
          push      = 1'b1;
          fetchPc_d = fetchPc_q + 32'd4;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (redirectTaken) begin
      flush     = 1'b1;
      push      = 1'b0;
      fetchPc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d   = FAULT;
        fault_d   = 1'b1;
        faultPc_d = redirect_pc;
      end else begin
        state_d = FETCH;
        fault_d = 1'b0;
      end
    end
  end

  // FIFO bookkeeping; a flush empties the buffer regardless of push/pop.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rdPtr_d = ptrInc(rdPtr_q);
      end
      if (push) begin
        wrPtr_d = ptrInc(wrPtr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stall counter only sees genuine back-pressure while fetching.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((state_q == FETCH) && fifoFull && !pop && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetchPc_q  <= RESET_PC;
      fault_q    <= 1'b0;
      faultPc_q  <= '0;
      stallCnt_q <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      fault_q    <= fault_d;
      faultPc_q  <= faultPc_d;
      stallCnt_q <= stallCnt_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        instrMem_q[i] <= '0;
      end
    end else if (push) begin
      pcMem_q[wrPtr_q]    <= fetchPc_q;
      instrMem_q[wrPtr_q] <= imem_instr;
    end
  end

endmodule
